// File: rtl/parallel_in_port_pkg.sv
// Shared address map and decode helper for the parallel input port.
// The display output port sits at 8'hFF, directly above these two addresses.
package parallel_in_port_pkg;

  localparam logic [7:0] PIN_DATA_ADDR       = 8'hFE;
  localparam logic [7:0] PIN_STATUS_ADDR     = 8'hFD;
  localparam int         PIN_DEBOUNCE_CYCLES = 4;

  typedef enum logic [1:0] {
    PIN_SEL_NONE   = 2'd0,
    PIN_SEL_DATA   = 2'd1,
    PIN_SEL_STATUS = 2'd2
  } pin_sel_e;

  function automatic pin_sel_e pin_decode(input logic       re,
                                          input logic [7:0] addr,
                                          input logic [7:0] data_addr,
                                          input logic [7:0] status_addr);
    pin_sel_e sel;
    sel = PIN_SEL_NONE;
    if (re && (addr == data_addr)) begin
      sel = PIN_SEL_DATA;
    end else if (re && (addr == status_addr)) begin
      sel = PIN_SEL_STATUS;
    end else begin
      sel = PIN_SEL_NONE;
    end
    return sel;
  endfunction

endpackage

// File: rtl/parallel_in_port_if.sv
// Core load path plus external input bus of the parallel input port.
// The port itself uses the slave view; the core/board side uses the master view.
interface parallel_in_port_if;

  logic [7:0] Address;
  logic       RE;
  logic [7:0] DataIn;
  logic [7:0] ReadData;
  logic       Changed;

  modport slave (
    input  Address,
    input  RE,
    input  DataIn,
    output ReadData,
    output Changed
  );

  modport master (
    output Address,
    output RE,
    output DataIn,
    input  ReadData,
    input  Changed
  );

endinterface

// File: rtl/parallel_in_port_debouncer.sv
// Two-flop synchronizer followed by a run-length debouncer; accept pulses for
// one cycle, ending on the edge that loads a new value into stable.
module input_debouncer #(
  parameter int WIDTH  = 8,
  parameter int CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] stable,
  output logic             accept
);

  localparam int            CW      = $clog2(CYCLES + 1);
  localparam logic [CW-1:0] CNT_SAT = CW'(CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [WIDTH-1:0] sync1_r;
  logic [WIDTH-1:0] sync2_r;
  logic [WIDTH-1:0] cand_r;
  logic [WIDTH-1:0] stable_r;
  logic [CW-1:0]    cnt_r;
  logic             diff_s;
  logic             sat_s;
  logic             accept_s;

  // Metastability guard: plain flop-to-flop path from sync1 to sync2
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_r <= {WIDTH{1'b0}};
      sync2_r <= {WIDTH{1'b0}};
    end else begin
      sync1_r <= din;
      sync2_r <= sync1_r;
    end
  end

  // Acceptance condition for the current synchronized sample
  always_comb begin
    diff_s   = (sync2_r != cand_r);
    sat_s    = (cnt_r >= CNT_SAT);
    accept_s = 1'b0;
    if (!diff_s && sat_s && (cand_r != stable_r)) begin
      accept_s = 1'b1;
    end else begin
      accept_s = 1'b0;
    end
  end

  // Candidate tracking, saturating stability counter and stable register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cand_r   <= {WIDTH{1'b0}};
      cnt_r    <= {CW{1'b0}};
      stable_r <= {WIDTH{1'b0}};
    end else if (diff_s) begin
      cand_r <= sync2_r;
      cnt_r  <= {CW{1'b0}};
    end else if (!sat_s) begin
      cnt_r <= cnt_r + CNT_ONE;
    end else if (accept_s) begin
      stable_r <= cand_r;
    end
  end

  assign stable = stable_r;
  assign accept = accept_s;

endmodule

// File: rtl/parallel_in_port.sv
// Memory-mapped, read-only parallel input port: debounced data byte, status
// byte and a sticky read-to-clear Changed flag.
module parallel_in_port
  import parallel_in_port_pkg::*;
#(
  parameter logic [7:0] DATA_ADDR       = PIN_DATA_ADDR,
  parameter logic [7:0] STATUS_ADDR     = PIN_STATUS_ADDR,
  parameter int         DEBOUNCE_CYCLES = PIN_DEBOUNCE_CYCLES
) (
  input logic               clk,
  input logic               rst,
  parallel_in_port_if.slave bus
);

  logic [7:0] stable_s;
  logic       accept_s;
  logic       changed_r;
  pin_sel_e   sel_s;
  logic [7:0] rdata_s;

  input_debouncer #(
    .WIDTH  (8),
    .CYCLES (DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk    (clk),
    .rst    (rst),
    .din    (bus.DataIn),
    .stable (stable_s),
    .accept (accept_s)
  );

  // Address decode of the load strobe
  always_comb begin
    sel_s = pin_decode(bus.RE, bus.Address, DATA_ADDR, STATUS_ADDR);
  end

  // Sticky flag: a new acceptance beats a coincident data read
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      changed_r <= 1'b0;
    end else if (accept_s) begin
      changed_r <= 1'b1;
    end else if (sel_s == PIN_SEL_DATA) begin
      changed_r <= 1'b0;
    end
  end

  // Read mux; zero when unselected so it can be OR-ed onto the load bus
  always_comb begin
    rdata_s = 8'h00;
    case (sel_s)
      PIN_SEL_DATA:   rdata_s = stable_s;
      PIN_SEL_STATUS: rdata_s = {7'b0000000, changed_r};
      default:        rdata_s = 8'h00;
    endcase
  end

  assign bus.ReadData = rdata_s;
  assign bus.Changed  = changed_r;

endmodule

// File: tb/tb_parallel_in_port.sv
// Scoreboard bench for parallel_in_port: a run-length reference model predicts
// ReadData/Changed per cycle, a negedge monitor compares, directed checks cover latency.
module tb_parallel_in_port;

  localparam int         DEB    = 4;
  localparam logic [7:0] A_DATA = 8'hFE;
  localparam logic [7:0] A_STAT = 8'hFD;
  localparam logic [7:0] A_OUT  = 8'hFF;

  logic clk = 1'b0;
  logic rst = 1'b0;

  parallel_in_port_if bus();

  parallel_in_port #(.DEBOUNCE_CYCLES(DEB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] rd;
    logic       chg;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: two-sample pipeline delay, then acceptance once the
  // delayed stream has shown the same value on DEB+1 consecutive edges.
  logic [7:0] m_pipe[2];
  logic [7:0] m_run_val;
  int         m_run_len;
  logic [7:0] m_stable;
  logic       m_changed;

  function automatic void model_reset();
    m_pipe[0] = 8'h00;
    m_pipe[1] = 8'h00;
    m_run_val = 8'h00;
    m_run_len = 1;
    m_stable  = 8'h00;
    m_changed = 1'b0;
  endfunction

  function automatic void model_edge(input logic [7:0] din, input logic re, input logic [7:0] addr);
    logic [7:0] s;
    logic       acc;
    if (!rst) begin
      model_reset();
    end else begin
      s         = m_pipe[1];
      m_pipe[1] = m_pipe[0];
      m_pipe[0] = din;
      if (s == m_run_val) m_run_len++;
      else begin
        m_run_val = s;
        m_run_len = 1;
      end
      acc = (m_run_len >= DEB + 1) && (m_run_val != m_stable);
      if (acc) begin
        m_stable  = m_run_val;
        m_changed = 1'b1;
      end else if (re && addr == A_DATA) begin
        m_changed = 1'b0;
      end
    end
  endfunction

  // Monitor: compare DUT outputs mid-cycle against the queued prediction
  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      n_checks++;
      if (bus.ReadData !== e.rd) begin
        n_fail++;
        $display("FAIL readdata t=%0t actual=%h required=%h", $time, bus.ReadData, e.rd);
      end
      n_checks++;
      if (bus.Changed !== e.chg) begin
        n_fail++;
        $display("FAIL changed t=%0t actual=%b required=%b", $time, bus.Changed, e.chg);
      end
    end
  end

  // One bus cycle: drive, predict, advance through the edge, step the model.
  task automatic cyc(input logic [7:0] din, input logic re, input logic [7:0] addr);
    exp_t e;
    bus.DataIn  = din;
    bus.RE      = re;
    bus.Address = addr;
    if (re && addr == A_DATA)      e.rd = m_stable;
    else if (re && addr == A_STAT) e.rd = {7'b0000000, m_changed};
    else                           e.rd = 8'h00;
    e.chg = m_changed;
    sb_q.push_back(e);
    @(posedge clk);
    model_edge(din, re, addr);
    #1;
  endtask

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Holds din with no reads; n = edge (E0 counted as 1) at which Changed rose, -1 on timeout.
  task automatic edges_to_changed(input logic [7:0] din, output int n);
    n = -1;
    for (int i = 1; i <= 20; i++) begin
      cyc(din, 1'b0, 8'h00);
      if (bus.Changed === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    int         n;
    int         rises;
    int         rise_at;
    logic       prev;
    logic [7:0] v;
    logic [7:0] a;
    int         hold;

    bus.DataIn  = 8'hA5;
    bus.RE      = 1'b0;
    bus.Address = 8'h00;
    model_reset();
    @(posedge clk);
    #1;

    // Reset held with live input
    for (int i = 0; i < 4; i++) cyc(8'hA5, 1'b1, A_DATA);
    cyc(8'hA5, 1'b1, A_STAT);
    check("reset_changed", int'(bus.Changed), 0);
    rst = 1'b1;
    edges_to_changed(8'hA5, n);
    check("reset_release_latency", n, 7);
    cyc(8'hA5, 1'b1, A_STAT);
    cyc(8'hA5, 1'b1, A_DATA);
    check("reset_read_clear", int'(bus.Changed), 0);

    // Clean change via 00 baseline
    edges_to_changed(8'h00, n);
    check("to_zero_latency", n, 7);
    cyc(8'h00, 1'b1, A_DATA);
    edges_to_changed(8'h3C, n);
    check("clean_latency", n, 7);
    cyc(8'h3C, 1'b1, A_STAT);
    cyc(8'h3C, 1'b1, A_STAT);
    check("status_no_clear", int'(bus.Changed), 1);
    cyc(8'h3C, 1'b1, A_DATA);
    check("data_read_clear", int'(bus.Changed), 0);

    // Glitch back at 00 baseline
    edges_to_changed(8'h00, n);
    cyc(8'h00, 1'b1, A_DATA);
    for (int i = 0; i < 10; i++) cyc(8'h00, 1'b0, 8'h00);
    rises = 0;
    for (int i = 0; i < 18; i++) begin
      cyc((i < 3) ? 8'hFF : 8'h00, 1'b0, 8'h00);
      if (bus.Changed === 1'b1) rises++;
    end
    check("glitch_no_change", rises, 0);
    cyc(8'h00, 1'b1, A_DATA);

    // Bounce: 2-cycle segments of 01/00, last toggle at cycle 8, then hold 01
    rises   = 0;
    rise_at = -1;
    prev    = bus.Changed;
    for (int i = 0; i < 22; i++) begin
      cyc(((i < 10) && ((i / 2) % 2 == 1)) ? 8'h00 : 8'h01, 1'b0, 8'h00);
      if (bus.Changed === 1'b1 && prev !== 1'b1) begin
        rises++;
        rise_at = i;
      end
      prev = bus.Changed;
    end
    check("bounce_accept_count", rises, 1);
    check("bounce_latency", rise_at - 8 + 1, 7);
    cyc(8'h01, 1'b1, A_DATA);

    // Collision: DATA read on the accept edge of 55
    for (int i = 0; i < 6; i++) cyc(8'h55, 1'b0, 8'h00);
    cyc(8'h55, 1'b1, A_DATA);
    check("collision_set_wins", int'(bus.Changed), 1);
    cyc(8'h55, 1'b1, A_DATA);
    check("collision_clear_after", int'(bus.Changed), 0);

    // Decode: unselected accesses leave the flag alone
    edges_to_changed(8'hAA, n);
    check("decode_setup_latency", n, 7);
    cyc(8'hAA, 1'b0, A_DATA);
    cyc(8'hAA, 1'b1, A_OUT);
    cyc(8'hAA, 1'b1, 8'h00);
    check("decode_flag_kept", int'(bus.Changed), 1);
    cyc(8'hAA, 1'b1, A_DATA);

    // Reset mid-debounce, then input 00 must not count as a change
    for (int i = 0; i < 3; i++) cyc(8'h0F, 1'b0, 8'h00);
    rst = 1'b0;
    model_reset();
    cyc(8'h0F, 1'b1, A_DATA);
    cyc(8'h00, 1'b1, A_STAT);
    rst = 1'b1;
    rises = 0;
    for (int i = 0; i < 12; i++) begin
      cyc(8'h00, 1'b1, A_STAT);
      if (bus.Changed === 1'b1) rises++;
    end
    check("reset_mid_debounce", rises, 0);

    // Randomized input runs with random accesses
    v    = 8'h00;
    hold = 0;
    for (int i = 0; i < 600; i++) begin
      if (hold == 0) begin
        v    = 8'($urandom);
        hold = $urandom_range(1, 9);
      end
      hold--;
      case ($urandom_range(0, 3))
        0:       a = A_DATA;
        1:       a = A_STAT;
        2:       a = A_OUT;
        default: a = 8'($urandom);
      endcase
      cyc(v, ($urandom_range(0, 2) != 0), a);
    end

    @(negedge clk);
    @(negedge clk);
    check("scoreboard_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
